// File: rtl/lfsr_pkg.sv
// Shared constants for the 20-bit Fibonacci LFSR (x^20 + x^13 + x^9 + x^5 + 1):
// register width, feedback taps and the stream-checker state encoding.
package lfsr_pkg;

  localparam int LFSR_W = 20;

  // Taps expressed on the receive window (w[0] oldest, w[19] newest).
  localparam int TAP_A = 15;
  localparam int TAP_B = 11;
  localparam int TAP_C = 7;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit predictor: the single tap definition used by both
// the LFSR generator and the stream checker.
module lfsr_predict
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] win_i,
  output logic              pred_o
);

  assign pred_o = win_i[TAP_A] ^ win_i[TAP_B] ^ win_i[TAP_C] ^ win_i[TAP_D];

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising receive checker for the 20-bit LFSR bit stream.
// Optional macro LFSR_CHK_STATE_EN adds the recovered_state output.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_code
`ifdef LFSR_CHK_STATE_EN
  ,
  output logic [LFSR_W-1:0] recovered_state
`endif
);

  localparam logic [4:0]       FILL_FULL = 5'(LFSR_W);
  localparam logic [7:0]       LOCK_TGT  = 8'(LOCK_CNT);
  localparam logic [3:0]       LOSS_TGT  = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] w_q, w_d;
  logic [4:0]        fill_q, fill_d;
  logic [7:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic [ERR_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic              pred_s;
  logic              mis_s;
  logic [7:0]        match_inc_s;
  logic [3:0]        miss_inc_s;

  lfsr_predict u_predict (
    .win_i  (w_q),
    .pred_o (pred_s)
  );

  assign mis_s       = din ^ pred_s;
  assign match_inc_s = match_q + 8'd1;
  assign miss_inc_s  = miss_q + 4'd1;

  // Next-state logic; the window always takes the received bit, never the prediction.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (din_valid) begin
      w_d = {din, w_q[LFSR_W-1:1]};
      case (state_q)
        HUNT: begin
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 5'd1;
          end else if (w_q == '0) begin
            fill_d = FILL_FULL;
          end else if (mis_s) begin
            err_d   = 1'b1;
            fill_d  = 5'd0;
            match_d = 8'd0;
          end else begin
            match_d = 8'd1;
            state_d = (8'd1 == LOCK_TGT) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (mis_s) begin
            err_d   = 1'b1;
            fill_d  = 5'd0;
            match_d = 8'd0;
            state_d = HUNT;
          end else begin
            match_d = match_inc_s;
            state_d = (match_inc_s == LOCK_TGT) ? LOCKED : VERIFY;
          end
        end
        LOCKED: begin
          if (mis_s) begin
            err_d = 1'b1;
            cnt_d = (cnt_q != '1) ? (cnt_q + ERR_ONE) : cnt_q;
            if (miss_inc_s == LOSS_TGT) begin
              state_d = HUNT;
              fill_d  = 5'd0;
              match_d = 8'd0;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_inc_s;
            end
          end else begin
            miss_d = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = 5'd0;
          match_d = 8'd0;
          miss_d  = 4'd0;
        end
      endcase
    end else begin
      w_d = w_q;
    end
    // A clear coinciding with an increment must win.
    if (clr_err) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end
    locked_d = (state_d == LOCKED);
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      w_q      <= '0;
      fill_q   <= 5'd0;
      match_q  <= 8'd0;
      miss_q   <= 4'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

`ifdef LFSR_CHK_STATE_EN
  logic [LFSR_W-1:0] rec_q;

  // Recovered generator state, published with the same timing as locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q <= '0;
    end else begin
      rec_q <= locked_d ? w_d : '0;
    end
  end

  assign recovered_state = rec_q;
`endif

  assign locked     = locked_q;
  assign err_pulse  = err_q;
  assign err_count  = cnt_q;
  assign state_code = state_q;

endmodule
